pause_dim_ctrl: RTL and testbench

Parametrised pause and screen-dim controller that sits between the arcade core and `arcade_video` in each arcade `emu` top level. It merges a user pause toggle, N level-held pause requesters (hiscore RAM access, etc.) and, optionally, the OSD into a single registered `pause`. After a configurable idle time in user pause it dims the RGB stream, switching dim on only at a frame boundary. It generalises the fixed 8-bit 3/3/2, single-requester, 24 MHz/10 s pause logic to arbitrary channel widths, requester count, clock rate and dim depth.

---
 rtl/pause_pkg.sv | 17 +
 rtl/rgb_dimmer.sv | 51 +++++
 rtl/pause_dim_ctrl.sv | 146 ++++++++++++++
 tb/tb_pause_dim_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pause_pkg.sv
// pause_pkg: shared types and defaults for the arcade pause / screen-dim logic.
//   pause_state_t   : pause FSM state encoding
//   DEF_CLK_HZ      : default clk_sys frequency for arcade tops
//   DEF_DIM_SECONDS : default user-pause time before the picture dims
package pause_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        UPAUSE   = 2'd1,
        DIM_PEND = 2'd2,
        DIMMED   = 2'd3
    } pause_state_t;

    localparam int unsigned DEF_CLK_HZ      = 24000000;
    localparam int unsigned DEF_DIM_SECONDS = 10;

endpackage : pause_pkg

// File: rtl/rgb_dimmer.sv
// rgb_dimmer: pixel register that optionally darkens each colour channel.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ce_pix_i      : pixel clock enable; the output only updates on it
//   dim_i         : when high, each channel is shifted right by DIM_SHIFT
//   rgb_i         : packed {R,G,B} pixel in
//   rgb_o         : packed {R,G,B} pixel out, one ce_pix strobe later
module rgb_dimmer #(
    parameter int unsigned RW        = 3,
    parameter int unsigned GW        = 3,
    parameter int unsigned BW        = 2,
    parameter int unsigned DIM_SHIFT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ce_pix_i,
    input  logic                  dim_i,
    input  logic [RW+GW+BW-1:0]   rgb_i,
    output logic [RW+GW+BW-1:0]   rgb_o
);

    localparam int unsigned PW = RW + GW + BW;

    logic [RW-1:0] r_c;
    logic [GW-1:0] g_c;
    logic [BW-1:0] b_c;
    logic [PW-1:0] pix_c;
    logic [PW-1:0] rgb_d;
    logic [PW-1:0] rgb_q;

    // Split channels and build the zero-filled dimmed pixel.
    always_comb begin
        r_c   = rgb_i[PW-1 -: RW];
        g_c   = rgb_i[GW+BW-1 -: GW];
        b_c   = rgb_i[BW-1:0];
        pix_c = dim_i ? {r_c >> DIM_SHIFT, g_c >> DIM_SHIFT, b_c >> DIM_SHIFT} : rgb_i;
        rgb_d = ce_pix_i ? pix_c : rgb_q;
    end

    // Pixel register; holds between strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule : rgb_dimmer

// File: rtl/pause_dim_ctrl.sv
// pause_dim_ctrl: merges the user pause toggle, N_REQ level-held pause
// requesters and (optionally) the OSD into one registered pause, and dims
// the RGB stream after DIM_SECONDS of user pause, starting at a vblank edge.
// Optional feature: define PAUSE_OSD_EN to let osd_status force pause.
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   ce_pix           : pixel clock enable for the RGB register
//   user_btn         : pause button level; a rising edge toggles user pause
//   pause_req        : per-requester level; each holds pause while high
//   osd_status       : OSD open (only used with PAUSE_OSD_EN)
//   vblank           : core vertical blank
//   rgb_in / rgb_out : packed {R,G,B} from core / to video
//   pause            : registered pause to the core
//   user_paused      : user toggle state
//   dim_active       : dimming applied to the RGB path
module pause_dim_ctrl
    import pause_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned DIM_SECONDS = DEF_DIM_SECONDS,
    parameter int unsigned RW          = 3,
    parameter int unsigned GW          = 3,
    parameter int unsigned BW          = 2,
    parameter int unsigned DIM_SHIFT   = 1,
    parameter int unsigned N_REQ       = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ce_pix,
    input  logic                  user_btn,
    input  logic [N_REQ-1:0]      pause_req,
    input  logic                  osd_status,
    input  logic                  vblank,
    input  logic [RW+GW+BW-1:0]   rgb_in,
    output logic                  pause,
    output logic                  user_paused,
    output logic                  dim_active,
    output logic [RW+GW+BW-1:0]   rgb_out
);

    localparam int unsigned DIM_CYCLES = CLK_HZ * DIM_SECONDS;
    localparam int unsigned CW         = $clog2(DIM_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIM_CYCLES);
    // Leaving UPAUSE on the last increment puts saturation and DIM_PEND in the same cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(DIM_CYCLES - 1);

    pause_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_q;
    logic          vb_q;
    logic          armed_q;
    logic          pause_q, pause_d;
    logic          up_q, up_d;
    logic          dim_q, dim_d;
    logic          rise_c;
    logic          vb_rise_c;
    logic          osd_pause_c;

`ifdef PAUSE_OSD_EN
    assign osd_pause_c = osd_status;
`else
    logic unused_osd;
    assign unused_osd  = osd_status;
    assign osd_pause_c = 1'b0;
`endif

    // armed_q masks the first edge after reset so a held button cannot toggle.
    assign rise_c    = user_btn & ~btn_q & armed_q;
    assign vb_rise_c = vblank & ~vb_q;

    // Next state, dim counter and registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            RUN: begin
                if (rise_c) state_d = UPAUSE;
            end
            UPAUSE: begin
                if (rise_c)                 state_d = RUN;
                else if (cnt_q >= CNT_LAST) state_d = DIM_PEND;
            end
            DIM_PEND: begin
                if (rise_c)         state_d = RUN;
                else if (vb_rise_c) state_d = DIMMED;
            end
            DIMMED: begin
                if (rise_c) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (state_d == RUN) begin
            cnt_d = '0;
        end else if ((state_q == UPAUSE) && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end

        up_d    = (state_d != RUN);
        dim_d   = (state_d == DIMMED);
        pause_d = (|pause_req) | up_d | osd_pause_c;
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            vb_q    <= 1'b0;
            armed_q <= 1'b0;
            pause_q <= 1'b0;
            up_q    <= 1'b0;
            dim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= user_btn;
            vb_q    <= vblank;
            armed_q <= 1'b1;
            pause_q <= pause_d;
            up_q    <= up_d;
            dim_q   <= dim_d;
        end
    end

    assign pause       = pause_q;
    assign user_paused = up_q;
    assign dim_active  = dim_q;

    rgb_dimmer #(
        .RW        (RW),
        .GW        (GW),
        .BW        (BW),
        .DIM_SHIFT (DIM_SHIFT)
    ) u_rgb_dimmer (
        .clk_i    (clk_sys),
        .rst_ni   (reset_n),
        .ce_pix_i (ce_pix),
        .dim_i    (dim_q),
        .rgb_i    (rgb_in),
        .rgb_o    (rgb_out)
    );

endmodule : pause_dim_ctrl

// File: tb/tb_pause_dim_ctrl.sv
// tb_pause_dim_ctrl: self-checking bench for pause_dim_ctrl with
// CLK_HZ=1000, DIM_SECONDS=1 (dim after 1000 cycles of user pause).
module tb_pause_dim_ctrl;

    logic       clk_sys;
    logic       reset_n;
    logic       ce_pix;
    logic       user_btn;
    logic [1:0] pause_req;
    logic       osd_status;
    logic       vblank;
    logic [7:0] rgb_in;
    logic       pause;
    logic       user_paused;
    logic       dim_active;
    logic [7:0] rgb_out;

    int errors = 0;
    int checks = 0;

`ifdef PAUSE_OSD_EN
    localparam logic OSD_PAUSE = 1'b1;
`else
    localparam logic OSD_PAUSE = 1'b0;
`endif

    typedef struct packed {
        logic p;
        logic u;
        logic d;
    } exp_t;

    exp_t       exq[$];
    logic [7:0] rgbq[$];

    pause_dim_ctrl #(
        .CLK_HZ      (1000),
        .DIM_SECONDS (1)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .user_btn    (user_btn),
        .pause_req   (pause_req),
        .osd_status  (osd_status),
        .vblank      (vblank),
        .rgb_in      (rgb_in),
        .pause       (pause),
        .user_paused (user_paused),
        .dim_active  (dim_active),
        .rgb_out     (rgb_out)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Push the expected flag triple, advance one cycle, pop and compare.
    task automatic step_and_score(input string nm, input logic ep, input logic eu, input logic ed);
        exp_t e;
        exq.push_back({ep, eu, ed});
        tick();
        e = exq.pop_front();
        checks += 3;
        if (pause !== e.p) begin
            errors++;
            $display("FAIL %s pause got %b want %b at %0t", nm, pause, e.p, $time);
        end
        if (user_paused !== e.u) begin
            errors++;
            $display("FAIL %s user_paused got %b want %b at %0t", nm, user_paused, e.u, $time);
        end
        if (dim_active !== e.d) begin
            errors++;
            $display("FAIL %s dim_active got %b want %b at %0t", nm, dim_active, e.d, $time);
        end
    endtask

    // One ce_pix strobe; expected pixel is queued with the stimulus.
    task automatic pix(input string nm, input logic [7:0] v, input logic [7:0] exp_v);
        logic [7:0] e;
        rgb_in = v;
        ce_pix = 1'b1;
        rgbq.push_back(exp_v);
        tick();
        ce_pix = 1'b0;
        e = rgbq.pop_front();
        checks++;
        if (rgb_out !== e) begin
            errors++;
            $display("FAIL %s rgb_out got %h want %h", nm, rgb_out, e);
        end
    endtask

    task automatic check_cnt(input string nm, input int exp_c);
        checks++;
        if (int'(dut.cnt_q) !== exp_c) begin
            errors++;
            $display("FAIL %s counter got %0d want %0d", nm, dut.cnt_q, exp_c);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        ce_pix     = 1'b0;
        user_btn   = 1'b0;
        pause_req  = 2'b00;
        osd_status = 1'b0;
        vblank     = 1'b0;
        rgb_in     = 8'h00;
        repeat (2) tick();
        checks += 4;
        if (pause !== 1'b0)       begin errors++; $display("FAIL reset pause got %b want 0", pause); end
        if (user_paused !== 1'b0) begin errors++; $display("FAIL reset user_paused got %b want 0", user_paused); end
        if (dim_active !== 1'b0)  begin errors++; $display("FAIL reset dim_active got %b want 0", dim_active); end
        if (rgb_out !== 8'h00)    begin errors++; $display("FAIL reset rgb_out got %h want 00", rgb_out); end
        reset_n = 1'b1;
        repeat (3) step_and_score("idle", 1'b0, 1'b0, 1'b0);
        pix("run_pix", 8'h5A, 8'h5A);
    endtask

    task automatic test_user_pause_dim();
        user_btn = 1'b1;
        step_and_score("toggle_on", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b0;
        for (int i = 0; i < 999; i++) step_and_score("counting", 1'b1, 1'b1, 1'b0);
        // vblank edge lands on the cycle the timer expires: too early to dim.
        vblank = 1'b1;
        step_and_score("expire", 1'b1, 1'b1, 1'b0);
        check_cnt("saturate", 1000);
        repeat (5) step_and_score("vb_held", 1'b1, 1'b1, 1'b0);
        vblank = 1'b0;
        step_and_score("vb_low", 1'b1, 1'b1, 1'b0);
        vblank = 1'b1;
        step_and_score("dim_on", 1'b1, 1'b1, 1'b1);
        vblank = 1'b0;
        check_cnt("sat_hold", 1000);
        pix("dim_ff", 8'hFF, 8'b011_011_01);
        pix("dim_a5", 8'hA5, 8'b010_000_00);
        pix("dim_5a", 8'h5A, 8'b001_011_01);
    endtask

    task automatic test_resume();
        user_btn = 1'b1;
        step_and_score("resume", 1'b0, 1'b0, 1'b0);
        user_btn = 1'b0;
        check_cnt("resume_cnt", 0);
        pix("undim_ff", 8'hFF, 8'hFF);
        rgb_in = 8'h12;
        repeat (3) step_and_score("rgb_hold", 1'b0, 1'b0, 1'b0);
        checks++;
        if (rgb_out !== 8'hFF) begin
            errors++;
            $display("FAIL rgb_hold rgb_out got %h want ff", rgb_out);
        end
    endtask

    task automatic test_hold_req();
        pause_req = 2'b01;
        for (int i = 0; i < 50; i++) step_and_score("req_hold", 1'b1, 1'b0, 1'b0);
        check_cnt("req_cnt", 0);
        pause_req = 2'b00;
        step_and_score("req_release", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_req_and_rise();
        pause_req = 2'b10;
        user_btn  = 1'b1;
        step_and_score("req_rise_on", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b0;
        step_and_score("req_upause", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b1;
        step_and_score("req_rise_off", 1'b1, 1'b0, 1'b0);
        user_btn  = 1'b0;
        pause_req = 2'b00;
        step_and_score("req_both_off", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_expiry_race();
        user_btn = 1'b1;
        step_and_score("exp_on", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b0;
        for (int i = 0; i < 999; i++) step_and_score("exp_count", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b1;
        step_and_score("exp_race", 1'b0, 1'b0, 1'b0);
        user_btn = 1'b0;
        check_cnt("exp_race_cnt", 0);
        // Must not have entered DIM_PEND: a vblank edge now cannot dim.
        vblank = 1'b1;
        step_and_score("exp_vb", 1'b0, 1'b0, 1'b0);
        vblank = 1'b0;
    endtask

    task automatic test_vblank_race();
        user_btn = 1'b1;
        step_and_score("vbr_on", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b0;
        for (int i = 0; i < 1000; i++) step_and_score("vbr_count", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b1;
        vblank   = 1'b1;
        step_and_score("vbr_race", 1'b0, 1'b0, 1'b0);
        user_btn = 1'b0;
        vblank   = 1'b0;
        step_and_score("vbr_after", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        user_btn = 1'b1;
        step_and_score("rst_on", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b0;
        for (int i = 0; i < 500; i++) step_and_score("rst_count", 1'b1, 1'b1, 1'b0);
        check_cnt("rst_pre", 500);
        user_btn = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (pause !== 1'b0)       begin errors++; $display("FAIL async_rst pause got %b want 0", pause); end
        if (user_paused !== 1'b0) begin errors++; $display("FAIL async_rst user_paused got %b want 0", user_paused); end
        if (dim_active !== 1'b0)  begin errors++; $display("FAIL async_rst dim_active got %b want 0", dim_active); end
        if (rgb_out !== 8'h00)    begin errors++; $display("FAIL async_rst rgb_out got %h want 00", rgb_out); end
        check_cnt("async_rst_cnt", 0);
        tick();
        reset_n = 1'b1;
        repeat (5) step_and_score("held_btn", 1'b0, 1'b0, 1'b0);
        user_btn = 1'b0;
        step_and_score("btn_fall", 1'b0, 1'b0, 1'b0);
        user_btn = 1'b1;
        step_and_score("btn_rerise", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b0;
        step_and_score("btn_low", 1'b1, 1'b1, 1'b0);
        user_btn = 1'b1;
        step_and_score("btn_resume", 1'b0, 1'b0, 1'b0);
        user_btn = 1'b0;
    endtask

    task automatic test_osd();
        osd_status = 1'b1;
        step_and_score("osd_on", OSD_PAUSE, 1'b0, 1'b0);
        step_and_score("osd_hold", OSD_PAUSE, 1'b0, 1'b0);
        osd_status = 1'b0;
        step_and_score("osd_off", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_user_pause_dim();
        test_resume();
        test_hold_req();
        test_req_and_rise();
        test_expiry_race();
        test_vblank_race();
        test_reset_mid();
        test_osd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pause_dim_ctrl
